pack_clr_pipe: RTL and testbench
================================

// Module: pack_clr_pipe
// PURPOSE
//  Narrow-to-wide beat packer with a registered valid/ready output and a synchronous clear.
//  Collects RATIO = OUT_W/IN_W narrow beats, lane 0 in the LSBs, into one wide word.
//  Feeds the downstream 256-bit forward-registered pipe stages.
//  A beat with f_last_in set flushes a partial word; unfilled lanes are zero, and the filled-lane count is reported.
// PARAMETERS
//  IN_W   32   narrow input beat width
//  OUT_W  256  wide output word width; OUT_W % IN_W == 0 and OUT_W/IN_W >= 2 (checked at elaboration)
//  Derived localparams: RATIO = OUT_W/IN_W; LANE_W = $clog2(RATIO); CNT_W = $clog2(RATIO)+1
// PORTS
//  clk          in   1      clock
//  rst_n        in   1      async reset, active low
//  clr          in   1      sync clear; discards the partial word and the output word
//  f_valid_in   in   1      upstream beat valid
//  f_data_in    in   IN_W   upstream beat data
//  f_last_in    in   1      beat closes the current word (flush)
//  f_ready_out  out  1      beat accepted when f_valid_in & f_ready_out
//  b_valid_out  out  1      wide word valid
//  b_data_out   out  OUT_W  wide word; lane k = bits [k*IN_W +: IN_W]
//  b_cnt_out    out  CNT_W  filled lanes in the word, 1..RATIO
//  b_last_out   out  1      word was closed by f_last_in
//  b_ready_in   in   1      downstream ready
// BEHAVIOUR
//  - Reset (async, rst_n=0): lane_cnt=0, asm=0, b_valid_out=0, b_data_out=0, b_cnt_out=0, b_last_out=0.
//  - f_ready_out = ~b_valid_out | b_ready_in. This is combinational and does not depend on f_valid_in or f_last_in.
//  - On an accepted beat, let word_done = (lane_cnt==RATIO-1) | f_last_in:
//    - ~word_done: asm[lane_cnt] <= f_data_in; lane_cnt <= lane_cnt+1.
//    - word_done: the output register loads asm with the current beat merged into lane lane_cnt.
//      Also b_cnt_out <= lane_cnt+1, b_last_out <= f_last_in, b_valid_out <= 1.
//      Then asm <= 0 and lane_cnt <= 0.
//  - Latency: a word is visible on b_* in the cycle after its completing beat is accepted.
//  - Throughput: one narrow beat per cycle while b_ready_in=1.
//  - Output handshake with no new word: b_valid_out & b_ready_in -> b_valid_out <= 0. Data, cnt and last hold their values.
//  - Simultaneous drain and load: b_valid_out stays 1 and the new word replaces the old one. No bubble, no loss.
//  - Stall: while b_valid_out & ~b_ready_in, b_data_out, b_cnt_out and b_last_out stay stable. No beat is accepted.
//  - f_last_in on the RATIO-th lane gives a full word with b_last_out=1 and b_cnt_out=RATIO.
//  - f_last_in on lane 0 gives b_cnt_out=1, with lanes 1..RATIO-1 zero.
//  - clr has priority over every other event in the same cycle:
//    - lane_cnt=0, asm=0, b_valid_out=0, b_data_out=0, b_cnt_out=0, b_last_out=0.
//    - A beat presented in the clr cycle is dropped, even if f_ready_out=1.
//  - Reset asserted mid-word discards the partial word with no output. The next beat starts at lane 0.
//  - b_valid_out never drops without a handshake, except under clr or reset.
// STRUCTURE
//  - No shared package needed: RATIO, LANE_W and CNT_W are local derived params.
//  - Lane write uses an indexed part-select on asm; no per-lane generate is required.
//  - The output holding register (valid, data, cnt, last) is a forward-registered valid/ready slice with sync clear.
//    It is written inline, not as a sub-module.
//  - Lane counter and assembly register form one always block.
//  - The output slice forms a second always block.
// TESTING (IN_W=32, OUT_W=256, RATIO=8, CNT_W=4)
//  1. 8 beats 0x1..0x8, b_ready_in=1, no last.
//     Expect: one word 0x00000008_..._00000001, b_cnt_out=8, b_last_out=0, valid one cycle after the 8th accept.
//  2. 3 beats 0xA,0xB,0xC with last on 0xC.
//     Expect: b_data_out[95:0]=0x0000000C_0000000B_0000000A, upper 160 bits 0, b_cnt_out=3, b_last_out=1.
//  3. 24 beats streaming; hold b_ready_in=0 for 10 cycles after the first word.
//     Expect: f_ready_out=0 during the hold, word 1 stable; then 3 words in order with no loss or duplication.
//  4. 5 beats accepted, then clr asserted together with a valid beat, then 8 beats 0x10..0x17.
//     Expect: the clr beat is dropped, no partial word is emitted, next word lanes = 0x10..0x17.
//  5. rst_n pulsed low mid-word (after 4 beats) while b_valid_out=1 and stalled.
//     Expect: all outputs 0 immediately; next word starts at lane 0.
//  6. Random valid/ready, 1000 beats, random last.
//     Scoreboard: every beat appears once in order; b_cnt_out matches; b_* stable under stall.

Source files
------------

// File: rtl/pack_clr_pipe_pkg.sv
// Shared defaults and geometry helper for the narrow-to-wide beat packer.
package pack_clr_pipe_pkg;

  localparam int PCP_IN_W  = 32;
  localparam int PCP_OUT_W = 256;

  // The wide word must hold a whole number of narrow lanes, and at least two of them.
  function automatic bit pcp_geom_ok(input int in_w, input int out_w);
    return (in_w > 0) && ((out_w % in_w) == 0) && ((out_w / in_w) >= 2);
  endfunction

endpackage

// File: rtl/pack_clr_pipe.sv
// Narrow-to-wide beat packer. Lane 0 sits in the LSBs. A beat with f_last_in
// closes a partial word early, leaving the unfilled lanes zero.
// The output is a forward-registered valid/ready slice with a synchronous clear.
module pack_clr_pipe
  import pack_clr_pipe_pkg::*;
#(
  parameter int IN_W  = PCP_IN_W,
  parameter int OUT_W = PCP_OUT_W,
  localparam int RATIO  = OUT_W / IN_W,
  localparam int LANE_W = $clog2(OUT_W / IN_W),
  localparam int CNT_W  = $clog2(OUT_W / IN_W) + 1
)(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              f_valid_in,
  input  logic [IN_W-1:0]   f_data_in,
  input  logic              f_last_in,
  output logic              f_ready_out,
  output logic              b_valid_out,
  output logic [OUT_W-1:0]  b_data_out,
  output logic [CNT_W-1:0]  b_cnt_out,
  output logic              b_last_out,
  input  logic              b_ready_in
);

  if (!pcp_geom_ok(IN_W, OUT_W)) begin : g_bad_geom
    $error("pack_clr_pipe: OUT_W must be a multiple of IN_W with at least two lanes");
  end

  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(RATIO - 1);

  logic [LANE_W-1:0] r_lane_cnt;
  logic [OUT_W-1:0]  r_asm;
  logic              r_b_valid;
  logic [OUT_W-1:0]  r_b_data;
  logic [CNT_W-1:0]  r_b_cnt;
  logic              r_b_last;

  logic              w_accept;
  logic              w_done;
  logic [OUT_W-1:0]  w_merged;

  // The slice can take a new word whenever it is empty or draining this cycle.
  assign f_ready_out = ~r_b_valid | b_ready_in;
  assign w_accept    = f_valid_in & f_ready_out;
  assign w_done      = (r_lane_cnt == LAST_LANE) | f_last_in;

  // Assembly word with the current beat dropped into its lane.
  always_comb begin
    w_merged = r_asm;
    w_merged[int'(r_lane_cnt)*IN_W +: IN_W] = f_data_in;
  end

  // Lane counter and assembly register; a completed word restarts from lane 0 with a clean assembly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lane_cnt <= '0;
      r_asm      <= '0;
    end else if (clr) begin
      r_lane_cnt <= '0;
      r_asm      <= '0;
    end else if (w_accept) begin
      if (w_done) begin
        r_lane_cnt <= '0;
        r_asm      <= '0;
      end else begin
        r_lane_cnt <= r_lane_cnt + LANE_W'(1);
        r_asm      <= w_merged;
      end
    end
  end

  // Output slice: load on word completion (replacing a draining word), otherwise drop valid on handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_b_valid <= 1'b0;
      r_b_data  <= '0;
      r_b_cnt   <= '0;
      r_b_last  <= 1'b0;
    end else if (clr) begin
      r_b_valid <= 1'b0;
      r_b_data  <= '0;
      r_b_cnt   <= '0;
      r_b_last  <= 1'b0;
    end else if (w_accept && w_done) begin
      r_b_valid <= 1'b1;
      r_b_data  <= w_merged;
      r_b_cnt   <= {1'b0, r_lane_cnt} + CNT_W'(1);
      r_b_last  <= f_last_in;
    end else if (r_b_valid && b_ready_in) begin
      r_b_valid <= 1'b0;
    end
  end

  assign b_valid_out = r_b_valid;
  assign b_data_out  = r_b_data;
  assign b_cnt_out   = r_b_cnt;
  assign b_last_out  = r_b_last;

endmodule

// File: tb/tb_pack_clr_pipe.sv
// Directed and random bench for pack_clr_pipe at IN_W=32, OUT_W=256.
module tb_pack_clr_pipe;

  logic         clk;
  logic         rst_n;
  logic         clr;
  logic         f_valid_in;
  logic [31:0]  f_data_in;
  logic         f_last_in;
  logic         f_ready_out;
  logic         b_valid_out;
  logic [255:0] b_data_out;
  logic [3:0]   b_cnt_out;
  logic         b_last_out;
  logic         b_ready_in;

  typedef struct packed {
    logic [255:0] d;
    logic [3:0]   c;
    logic         l;
  } word_t;

  word_t        got_q[$];
  word_t        exp_q[$];
  logic [255:0] m_asm;
  int           m_lane;
  int           n_pass;
  int           n_total;

  logic         prev_stall;
  logic [255:0] p_data;
  logic [3:0]   p_cnt;
  logic         p_last;

  pack_clr_pipe #(.IN_W(32), .OUT_W(256)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr         (clr),
    .f_valid_in  (f_valid_in),
    .f_data_in   (f_data_in),
    .f_last_in   (f_last_in),
    .f_ready_out (f_ready_out),
    .b_valid_out (b_valid_out),
    .b_data_out  (b_data_out),
    .b_cnt_out   (b_cnt_out),
    .b_last_out  (b_last_out),
    .b_ready_in  (b_ready_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Capture every output handshake; check b_* hold steady across stalled cycles.
  always @(negedge clk) begin
    if (prev_stall && rst_n) begin
      n_total++;
      if (b_valid_out !== 1'b1 || b_data_out !== p_data || b_cnt_out !== p_cnt || b_last_out !== p_last) begin
        $display("FAIL stall_stable: got v=%b cnt=%0d last=%b data=%h, want v=1 cnt=%0d last=%b data=%h",
                 b_valid_out, b_cnt_out, b_last_out, b_data_out, p_cnt, p_last, p_data);
      end else begin
        n_pass++;
      end
    end
    if (rst_n && !clr && b_valid_out === 1'b1 && b_ready_in === 1'b1)
      got_q.push_back('{b_data_out, b_cnt_out, b_last_out});
    prev_stall = rst_n && !clr && (b_valid_out === 1'b1) && (b_ready_in === 1'b0);
    p_data = b_data_out;
    p_cnt  = b_cnt_out;
    p_last = b_last_out;
  end

  function automatic void model_reset();
    m_asm  = '0;
    m_lane = 0;
  endfunction

  function automatic void model_accept(input logic [31:0] d, input logic l);
    m_asm[m_lane*32 +: 32] = d;
    if (m_lane == 7 || l) begin
      exp_q.push_back('{m_asm, 4'(m_lane + 1), l});
      m_asm  = '0;
      m_lane = 0;
    end else begin
      m_lane++;
    end
  endfunction

  // Called at posedge+1; returns at posedge+1 just after the beat was accepted.
  task automatic send_beat(input logic [31:0] d, input logic l);
    int guard;
    logic acc;
    guard = 0;
    f_valid_in = 1'b1;
    f_data_in  = d;
    f_last_in  = l;
    forever begin
      @(negedge clk);
      acc = f_ready_out;
      @(posedge clk);
      #1;
      if (acc) begin
        model_accept(d, l);
        break;
      end
      guard++;
      if (guard > 200) begin
        n_total++;
        $display("FAIL send_beat_timeout: beat %h not accepted, want accepted within 200 cycles", d);
        break;
      end
    end
    f_valid_in = 1'b0;
    f_last_in  = 1'b0;
  endtask

  task automatic compare_queues(input string name);
    b_ready_in = 1'b1;
    f_valid_in = 1'b0;
    repeat (20) begin
      @(posedge clk);
      #1;
    end
    n_total++;
    if (got_q.size() !== exp_q.size())
      $display("FAIL %s_word_count: got %0d words, want %0d", name, got_q.size(), exp_q.size());
    else
      n_pass++;
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_total++;
      if (got_q[i] !== exp_q[i])
        $display("FAIL %s_word%0d: got cnt=%0d last=%b data=%h, want cnt=%0d last=%b data=%h",
                 name, i, got_q[i].c, got_q[i].l, got_q[i].d, exp_q[i].c, exp_q[i].l, exp_q[i].d);
      else
        n_pass++;
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset();
    #2;
    n_total++;
    if (b_valid_out !== 1'b0 || b_data_out !== 256'h0 || b_cnt_out !== 4'd0 || b_last_out !== 1'b0)
      $display("FAIL reset_outputs: got v=%b cnt=%0d last=%b data=%h, want all zero",
               b_valid_out, b_cnt_out, b_last_out, b_data_out);
    else n_pass++;
    n_total++;
    if (f_ready_out !== 1'b1) $display("FAIL reset_ready: got %b, want 1", f_ready_out);
    else n_pass++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_full_word();
    b_ready_in = 1'b1;
    for (int i = 1; i <= 8; i++) send_beat(32'(i), 1'b0);
    n_total++;
    if (b_valid_out !== 1'b1 || b_cnt_out !== 4'd8 || b_last_out !== 1'b0 ||
        b_data_out !== 256'h00000008_00000007_00000006_00000005_00000004_00000003_00000002_00000001)
      $display("FAIL full_word: got v=%b cnt=%0d last=%b data=%h, want v=1 cnt=8 last=0 lanes 1..8",
               b_valid_out, b_cnt_out, b_last_out, b_data_out);
    else n_pass++;
    compare_queues("full_word");
  endtask

  task automatic test_last_flush();
    logic [255:0] want;
    want = {160'h0, 96'h0000000C_0000000B_0000000A};
    send_beat(32'hA, 1'b0);
    send_beat(32'hB, 1'b0);
    send_beat(32'hC, 1'b1);
    n_total++;
    if (b_valid_out !== 1'b1 || b_cnt_out !== 4'd3 || b_last_out !== 1'b1 || b_data_out !== want)
      $display("FAIL last_flush3: got v=%b cnt=%0d last=%b data=%h, want v=1 cnt=3 last=1 data=%h",
               b_valid_out, b_cnt_out, b_last_out, b_data_out, want);
    else n_pass++;
    send_beat(32'h55, 1'b1);
    n_total++;
    if (b_cnt_out !== 4'd1 || b_last_out !== 1'b1 || b_data_out !== 256'h55)
      $display("FAIL last_lane0: got cnt=%0d last=%b data=%h, want cnt=1 last=1 data=55",
               b_cnt_out, b_last_out, b_data_out);
    else n_pass++;
    for (int i = 0; i < 8; i++) send_beat(32'h70 + 32'(i), (i == 7));
    n_total++;
    if (b_cnt_out !== 4'd8 || b_last_out !== 1'b1 ||
        b_data_out !== 256'h00000077_00000076_00000075_00000074_00000073_00000072_00000071_00000070)
      $display("FAIL last_lane7: got cnt=%0d last=%b data=%h, want cnt=8 last=1 lanes 70..77",
               b_cnt_out, b_last_out, b_data_out);
    else n_pass++;
    compare_queues("last_flush");
  endtask

  task automatic test_stall();
    logic [255:0] w1;
    w1 = 256'h00000107_00000106_00000105_00000104_00000103_00000102_00000101_00000100;
    b_ready_in = 1'b1;
    for (int i = 0; i < 8; i++) send_beat(32'h100 + 32'(i), 1'b0);
    b_ready_in = 1'b0;
    f_valid_in = 1'b1;
    f_data_in  = 32'h108;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      n_total++;
      if (f_ready_out !== 1'b0 || b_valid_out !== 1'b1 || b_data_out !== w1)
        $display("FAIL stall_hold%0d: got rdy=%b v=%b data=%h, want rdy=0 v=1 data=%h",
                 c, f_ready_out, b_valid_out, b_data_out, w1);
      else n_pass++;
      @(posedge clk); #1;
    end
    f_valid_in = 1'b0;
    b_ready_in = 1'b1;
    for (int i = 8; i < 24; i++) send_beat(32'h100 + 32'(i), 1'b0);
    compare_queues("stall");
  endtask

  task automatic test_clr();
    b_ready_in = 1'b1;
    for (int i = 1; i <= 5; i++) send_beat(32'(i), 1'b0);
    clr        = 1'b1;
    f_valid_in = 1'b1;
    f_data_in  = 32'hDEAD;
    @(negedge clk);
    n_total++;
    if (f_ready_out !== 1'b1) $display("FAIL clr_ready: got %b, want 1", f_ready_out);
    else n_pass++;
    @(posedge clk); #1;
    clr        = 1'b0;
    f_valid_in = 1'b0;
    model_reset();
    n_total++;
    if (b_valid_out !== 1'b0 || b_cnt_out !== 4'd0 || b_data_out !== 256'h0)
      $display("FAIL clr_outputs: got v=%b cnt=%0d data=%h, want all zero", b_valid_out, b_cnt_out, b_data_out);
    else n_pass++;
    for (int i = 0; i < 8; i++) send_beat(32'h10 + 32'(i), 1'b0);
    n_total++;
    if (b_valid_out !== 1'b1 || b_cnt_out !== 4'd8 ||
        b_data_out !== 256'h00000017_00000016_00000015_00000014_00000013_00000012_00000011_00000010)
      $display("FAIL clr_next_word: got v=%b cnt=%0d data=%h, want v=1 cnt=8 lanes 10..17",
               b_valid_out, b_cnt_out, b_data_out);
    else n_pass++;
    compare_queues("clr");
  endtask

  task automatic pulse_reset(input string name);
    rst_n = 1'b0;
    #2;
    n_total++;
    if (b_valid_out !== 1'b0 || b_data_out !== 256'h0 || b_cnt_out !== 4'd0 || b_last_out !== 1'b0)
      $display("FAIL %s: got v=%b cnt=%0d last=%b data=%h, want all zero",
               name, b_valid_out, b_cnt_out, b_last_out, b_data_out);
    else n_pass++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset_mid();
    b_ready_in = 1'b1;
    for (int i = 0; i < 4; i++) send_beat(32'hEE0 + 32'(i), 1'b0);
    pulse_reset("reset_partial");
    b_ready_in = 1'b0;
    for (int i = 0; i < 8; i++) send_beat(32'h20 + 32'(i), 1'b0);
    n_total++;
    if (b_valid_out !== 1'b1 || f_ready_out !== 1'b0)
      $display("FAIL reset_prestall: got v=%b rdy=%b, want v=1 rdy=0", b_valid_out, f_ready_out);
    else n_pass++;
    pulse_reset("reset_stalled");
    b_ready_in = 1'b1;
    for (int i = 0; i < 8; i++) send_beat(32'h30 + 32'(i), 1'b0);
    n_total++;
    if (b_cnt_out !== 4'd8 ||
        b_data_out !== 256'h00000037_00000036_00000035_00000034_00000033_00000032_00000031_00000030)
      $display("FAIL reset_next_word: got cnt=%0d data=%h, want cnt=8 lanes 30..37", b_cnt_out, b_data_out);
    else n_pass++;
    compare_queues("reset_mid");
  endtask

  task automatic test_random();
    int acc_cnt;
    int cyc;
    bit have;
    logic a;
    logic [31:0] d;
    logic l;
    acc_cnt = 0;
    cyc     = 0;
    have    = 0;
    d       = '0;
    l       = 1'b0;
    while (acc_cnt < 1000 && cyc < 20000) begin
      b_ready_in = ($urandom_range(0, 3) != 0);
      if (!have) begin
        d    = 32'hC000_0000 + 32'(acc_cnt);
        l    = ($urandom_range(0, 5) == 0);
        have = 1;
      end
      f_valid_in = ($urandom_range(0, 3) != 0);
      f_data_in  = d;
      f_last_in  = l;
      @(negedge clk);
      a = f_valid_in & f_ready_out;
      @(posedge clk); #1;
      if (a) begin
        model_accept(d, l);
        acc_cnt++;
        have = 0;
      end
      cyc++;
    end
    f_valid_in = 1'b0;
    f_last_in  = 1'b0;
    if (acc_cnt < 1000) begin
      n_total++;
      $display("FAIL random_timeout: got %0d beats accepted, want 1000", acc_cnt);
    end
    b_ready_in = 1'b1;
    if (m_lane != 0) send_beat(32'hCFFF_FFFF, 1'b1);
    compare_queues("random");
  endtask

  initial begin
    n_pass     = 0;
    n_total    = 0;
    prev_stall = 1'b0;
    rst_n      = 1'b0;
    clr        = 1'b0;
    f_valid_in = 1'b0;
    f_data_in  = '0;
    f_last_in  = 1'b0;
    b_ready_in = 1'b0;
    model_reset();
    test_reset();
    test_full_word();
    test_last_flush();
    test_stall();
    test_clr();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
